// File: rtl/cr16_controller.sv
// CompactRISC16 fetch/decode/control unit: a multi-cycle FSM that fetches from
// word-addressed instruction memory and drives cr16_datapath control signals.
module cr16_controller (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_INSTR,
    input  logic [4:0]  I_FLAGS,
    output logic [15:0] O_MEM_ADDR,
    output logic        O_MEM_RD,
    output logic [15:0] O_REG_ENABLE,
    output logic [3:0]  O_OPCODE,
    output logic [3:0]  O_READ_PORT_A_SEL,
    output logic [3:0]  O_READ_PORT_B_SEL,
    output logic [15:0] O_IMMEDIATE,
    output logic        O_IMM_SEL,
    output logic        O_ALU_ENABLE,
    output logic        O_HALTED
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  f_op, f_rd, f_ext, f_rs;
    logic [7:0]  f_imm8;

    assign f_op   = ir_q[15:12];
    assign f_rd   = ir_q[11:8];
    assign f_ext  = ir_q[7:4];
    assign f_rs   = ir_q[3:0];
    assign f_imm8 = ir_q[7:0];

    // Only Z participates in branch resolution.
    logic unused_flags;
    assign unused_flags = ^{I_FLAGS[4], I_FLAGS[2:0]};

    // Shared ext/op code table: {valid, ALU opcode}.
    function automatic logic [4:0] alu_code(input logic [3:0] c);
        case (c)
            4'b0001: return {1'b1, 4'd3};
            4'b0010: return {1'b1, 4'd4};
            4'b0011: return {1'b1, 4'd5};
            4'b0101: return {1'b1, 4'd0};
            4'b1001: return {1'b1, 4'd1};
            4'b1011: return {1'b1, 4'd2};
            4'b1101: return {1'b1, 4'd6};
            default: return 5'b0;
        endcase
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    logic        dec_legal, dec_br, dec_alu_en, dec_wr, dec_imm_sel, br_taken;
    logic [3:0]  dec_opcode;
    logic [15:0] dec_imm;
    logic [4:0]  dec_code;

    always_comb begin
        dec_legal   = 1'b0;
        dec_br      = 1'b0;
        dec_alu_en  = 1'b0;
        dec_wr      = 1'b0;
        dec_imm_sel = 1'b0;
        dec_opcode  = 4'd0;
        dec_imm     = 16'h0000;
        dec_code    = 5'b0;
        case (f_op)
            4'b0000: begin
                dec_code   = alu_code(f_ext);
                dec_legal  = dec_code[4];
                dec_opcode = dec_code[3:0];
                dec_alu_en = dec_code[4];
                dec_wr     = dec_code[4] && (f_ext != 4'b1011);
            end
            4'b1000: begin
                if (f_ext == 4'b0100) begin
                    dec_legal  = 1'b1;
                    dec_opcode = 4'd7;
                    dec_alu_en = 1'b1;
                    dec_wr     = 1'b1;
                end else if (f_ext[3:1] == 3'b000) begin
                    dec_legal   = 1'b1;
                    dec_opcode  = 4'd7;
                    dec_alu_en  = 1'b1;
                    dec_wr      = 1'b1;
                    dec_imm_sel = 1'b1;
                    dec_imm     = sext5(ir_q[4:0]);
                end
            end
            4'b1100: begin
                dec_legal = 1'b1;
                dec_br    = 1'b1;
            end
            4'b1111: begin
                dec_legal   = 1'b1;
                dec_opcode  = 4'd6;
                dec_alu_en  = 1'b1;
                dec_wr      = 1'b1;
                dec_imm_sel = 1'b1;
                dec_imm     = {f_imm8, 8'h00};
            end
            default: begin
                // Immediate forms reuse the register-form ext code as op.
                dec_code = alu_code(f_op);
                if (dec_code[4]) begin
                    dec_legal   = 1'b1;
                    dec_opcode  = dec_code[3:0];
                    dec_alu_en  = 1'b1;
                    dec_wr      = (f_op != 4'b1011);
                    dec_imm_sel = 1'b1;
                    if (f_op == 4'b0101 || f_op == 4'b1001 || f_op == 4'b1011)
                        dec_imm = sext8(f_imm8);
                    else
                        dec_imm = {8'h00, f_imm8};
                end
            end
        endcase
    end

    assign br_taken = ((f_rd == 4'b0000) &&  I_FLAGS[3]) ||
                      ((f_rd == 4'b0001) && !I_FLAGS[3]) ||
                       (f_rd == 4'b1110);

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        ir_d              = ir_q;
        O_MEM_ADDR        = 16'h0000;
        O_MEM_RD          = 1'b0;
        O_REG_ENABLE      = 16'h0000;
        O_OPCODE          = 4'd0;
        O_READ_PORT_A_SEL = 4'd0;
        O_READ_PORT_B_SEL = 4'd0;
        O_IMMEDIATE       = 16'h0000;
        O_IMM_SEL         = 1'b0;
        O_ALU_ENABLE      = 1'b0;
        O_HALTED          = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                O_MEM_RD   = 1'b1;
                O_MEM_ADDR = pc_q;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                ir_d    = I_INSTR;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                O_READ_PORT_A_SEL = f_rd;
                O_READ_PORT_B_SEL = f_rs;
                if (dec_legal) begin
                    O_REG_ENABLE = dec_wr ? (16'h0001 << f_rd) : 16'h0000;
                    O_OPCODE     = dec_opcode;
                    O_IMMEDIATE  = dec_imm;
                    O_IMM_SEL    = dec_imm_sel;
                    O_ALU_ENABLE = dec_alu_en;
                    pc_d         = (dec_br && br_taken) ? pc_q + sext8(f_imm8) : pc_q + 16'd1;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  O_HALTED = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= S_IDLE;
            pc_q    <= 16'h0000;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_cr16_controller.sv
// Bench for cr16_controller: directed vector table, hand-written reset/halt
// sequences, and randomized instructions scored against an encoding-table model.
module tb_cr16_controller;

    logic        I_CLK = 1'b0;
    logic        I_RESET = 1'b1;
    logic [15:0] I_INSTR;
    logic [4:0]  I_FLAGS = 5'h00;
    logic [15:0] O_MEM_ADDR;
    logic        O_MEM_RD;
    logic [15:0] O_REG_ENABLE;
    logic [3:0]  O_OPCODE;
    logic [3:0]  O_READ_PORT_A_SEL;
    logic [3:0]  O_READ_PORT_B_SEL;
    logic [15:0] O_IMMEDIATE;
    logic        O_IMM_SEL;
    logic        O_ALU_ENABLE;
    logic        O_HALTED;

    cr16_controller dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_INSTR(I_INSTR), .I_FLAGS(I_FLAGS),
        .O_MEM_ADDR(O_MEM_ADDR), .O_MEM_RD(O_MEM_RD), .O_REG_ENABLE(O_REG_ENABLE),
        .O_OPCODE(O_OPCODE), .O_READ_PORT_A_SEL(O_READ_PORT_A_SEL),
        .O_READ_PORT_B_SEL(O_READ_PORT_B_SEL), .O_IMMEDIATE(O_IMMEDIATE),
        .O_IMM_SEL(O_IMM_SEL), .O_ALU_ENABLE(O_ALU_ENABLE), .O_HALTED(O_HALTED)
    );

    always #5 I_CLK = ~I_CLK;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    // Instruction memory with fixed one-cycle read latency; unwritten words are illegal.
    logic [15:0] mem [logic [15:0]];
    logic [15:0] instr_q = 16'h0000;
    assign I_INSTR = instr_q;
    always @(posedge I_CLK)
        if (O_MEM_RD) instr_q <= mem.exists(O_MEM_ADDR) ? mem[O_MEM_ADDR] : 16'h7000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] addr, input logic rd,
                                       input logic [15:0] ren, input logic [3:0] opc,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [15:0] imm, input logic isel,
                                       input logic alu, input logic halt);
        return {addr, rd, ren, opc, a, b, imm, isel, alu, halt};
    endfunction

    function automatic logic [63:0] outs();
        return pk(O_MEM_ADDR, O_MEM_RD, O_REG_ENABLE, O_OPCODE, O_READ_PORT_A_SEL,
                  O_READ_PORT_B_SEL, O_IMMEDIATE, O_IMM_SEL, O_ALU_ENABLE, O_HALTED);
    endfunction

    always @(negedge I_CLK)
        if (mon_on) chk("reg_enable_onehot", 64'($countones(O_REG_ENABLE) <= 1), 64'd1);

    // Legal-encoding table: immk 0 none, 1 sign-ext imm8, 2 zero-ext imm8, 3 sign-ext IR[4:0], 4 imm8<<8.
    typedef struct {
        logic [15:0] mask;
        logic [15:0] match;
        logic [3:0]  alu;
        int          immk;
        bit          wr;
        bit          alu_en;
        bit          br;
    } enc_t;
    enc_t encs[$];

    task automatic add_enc(input logic [15:0] m, input logic [15:0] v, input logic [3:0] alu,
                           input int immk, input bit wr, input bit alu_en, input bit br);
        enc_t e;
        e.mask = m; e.match = v; e.alu = alu; e.immk = immk;
        e.wr = wr; e.alu_en = alu_en; e.br = br;
        encs.push_back(e);
    endtask

    task automatic build_encs();
        logic [3:0]  codes [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
        logic [3:0]  alus  [7] = '{4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd6};
        int          kinds [7] = '{2, 2, 2, 1, 1, 1, 2};
        for (int i = 0; i < 7; i++) begin
            add_enc(16'hF0F0, {8'h00, codes[i], 4'h0}, alus[i], 0, codes[i] != 4'hB, 1, 0);
            add_enc(16'hF000, {codes[i], 12'h000}, alus[i], kinds[i], codes[i] != 4'hB, 1, 0);
        end
        add_enc(16'hF0F0, 16'h8040, 4'd7, 0, 1, 1, 0);
        add_enc(16'hF0E0, 16'h8000, 4'd7, 3, 1, 1, 0);
        add_enc(16'hF000, 16'hF000, 4'd6, 4, 1, 1, 0);
        add_enc(16'hF000, 16'hC000, 4'd0, 0, 0, 0, 1);
    endtask

    function automatic void model(input logic [15:0] w, input logic [4:0] fl, input logic [15:0] pc,
                                  output logic [63:0] eo, output logic [15:0] npc, output bit ill);
        int hit = -1;
        int v;
        logic [15:0] imm;
        bit taken;
        enc_t e;
        foreach (encs[i]) if (hit < 0 && (w & encs[i].mask) == encs[i].match) hit = i;
        ill = (hit < 0);
        if (ill) begin
            eo  = pk(16'h0, 1'b0, 16'h0, 4'd0, w[11:8], w[3:0], 16'h0, 1'b0, 1'b0, 1'b0);
            npc = pc;
            return;
        end
        e = encs[hit];
        case (e.immk)
            1: begin v = int'(w[7:0]); if (v > 127) v -= 256; imm = v[15:0]; end
            2: imm = {8'h00, w[7:0]};
            3: begin v = int'(w[4:0]); if (v > 15) v -= 32; imm = v[15:0]; end
            4: imm = w[7:0] * 16'd256;
            default: imm = 16'h0000;
        endcase
        npc = pc + 16'd1;
        if (e.br) begin
            taken = (w[11:8] == 4'd0 && fl[3]) || (w[11:8] == 4'd1 && !fl[3]) || (w[11:8] == 4'd14);
            v = int'(w[7:0]);
            if (v > 127) v -= 256;
            if (taken) npc = pc + v[15:0];
        end
        eo = pk(16'h0, 1'b0, e.wr ? 16'(1 << w[11:8]) : 16'h0, e.alu, w[11:8], w[3:0],
                imm, e.immk != 0, e.alu_en, 1'b0);
    endfunction

    logic [15:0] m_pc;

    // Entered from the negedge before FETCH; returns at the EXEC negedge.
    task automatic step_to_exec(input logic [15:0] w, input logic [4:0] fl);
        mem[m_pc] = w;
        @(negedge I_CLK);
        chk("fetch_addr", {O_MEM_RD, O_MEM_ADDR}, {1'b1, m_pc});
        @(negedge I_CLK);
        chk("latch_outs", outs(), 64'h0);
        I_FLAGS = fl;
        @(negedge I_CLK);
    endtask

    task automatic do_reset();
        I_RESET = 1'b1;
        repeat (2) @(posedge I_CLK);
        #1 I_RESET = 1'b0;
        @(negedge I_CLK);
        chk("idle_outs", outs(), 64'h0);
        m_pc = 16'h0000;
    endtask

    typedef struct {
        logic [15:0] w;
        logic [4:0]  fl;
        logic [15:0] ren;
        logic [3:0]  opc;
        logic [15:0] imm;
        logic        isel;
        logic        alu;
        logic [15:0] delta;
    } vec_t;

    initial begin
        vec_t vt[$];
        logic [63:0] eo;
        logic [15:0] npc, w;
        logic [4:0]  fl;
        bit ill;
        enc_t e;

        build_encs();
        vt.push_back(vec_t'{16'h01B2, 5'h08, 16'h0000, 4'd2, 16'h0000, 1'b0, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hC0FE, 5'h08, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 16'hFFFE});
        vt.push_back(vec_t'{16'h01D2, 5'h00, 16'h0002, 4'd6, 16'h0000, 1'b0, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hD105, 5'h00, 16'h0002, 4'd6, 16'h0005, 1'b1, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'h51FF, 5'h00, 16'h0002, 4'd0, 16'hFFFF, 1'b1, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'h01B2, 5'h00, 16'h0000, 4'd2, 16'h0000, 1'b0, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hC1FE, 5'h00, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 16'hFFFE});
        vt.push_back(vec_t'{16'hC0FE, 5'h00, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0001});
        vt.push_back(vec_t'{16'h8045, 5'h00, 16'h0001, 4'd7, 16'h0000, 1'b0, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'h801F, 5'h00, 16'h0001, 4'd7, 16'hFFFF, 1'b1, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hF3AB, 5'h00, 16'h0008, 4'd6, 16'hAB00, 1'b1, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'h1F80, 5'h00, 16'h8000, 4'd3, 16'h0080, 1'b1, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hBE80, 5'h00, 16'h0000, 4'd2, 16'hFF80, 1'b1, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hCE05, 5'h00, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0005});
        vt.push_back(vec_t'{16'h0F3A, 5'h00, 16'h8000, 4'd5, 16'h0000, 1'b0, 1'b1, 16'h0001});
        vt.push_back(vec_t'{16'hC2FE, 5'h08, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0001});

        // Reset held for two cycles, then the IDLE cycle must be all-zero.
        do_reset();
        mon_on = 1'b1;

        // Directed vectors: PC runs 0 -> 1 -> 0xFFFF -> 0 (wrap) -> ...
        foreach (vt[i]) begin
            step_to_exec(vt[i].w, vt[i].fl);
            chk($sformatf("vec%0d_exec", i), outs(),
                pk(16'h0, 1'b0, vt[i].ren, vt[i].opc, vt[i].w[11:8], vt[i].w[3:0],
                   vt[i].imm, vt[i].isel, vt[i].alu, 1'b0));
            m_pc = m_pc + vt[i].delta;
        end

        // Illegal word halts the core; only reset recovers.
        step_to_exec(16'h7000, 5'h00);
        chk("illegal_exec", outs(), pk(16'h0, 1'b0, 16'h0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0));
        repeat (12) begin
            @(negedge I_CLK);
            chk("halted_outs", outs(), pk(16'h0, 1'b0, 16'h0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1));
        end
        do_reset();

        // Reset asserted during EXEC of ADDI at PC=5 suppresses the PC update.
        for (int i = 0; i < 5; i++) begin
            step_to_exec(16'hD100 | 16'(i), 5'h00);
            m_pc = m_pc + 16'd1;
        end
        step_to_exec(16'h5103, 5'h00);
        chk("addi_at5_exec", outs(), pk(16'h0, 1'b0, 16'h0002, 4'd0, 4'd1, 4'd3, 16'h0003, 1'b1, 1'b1, 1'b0));
        I_RESET = 1'b1;
        @(posedge I_CLK);
        #1 I_RESET = 1'b0;
        @(negedge I_CLK);
        chk("midexec_reset_idle", outs(), 64'h0);
        m_pc = 16'h0000;

        // Randomized instructions, biased toward legal encodings.
        for (int n = 0; n < 80; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                e = encs[$urandom_range(0, encs.size() - 1)];
                w = (w & ~e.mask) | e.match;
            end
            fl = 5'($urandom);
            model(w, fl, m_pc, eo, npc, ill);
            step_to_exec(w, fl);
            chk($sformatf("rand%0d_exec_w%h", n, w), outs(), eo);
            if (ill) begin
                @(negedge I_CLK);
                chk("rand_halted", outs(), pk(16'h0, 1'b0, 16'h0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1));
                do_reset();
            end else begin
                m_pc = npc;
            end
        end
        step_to_exec(16'h0000, 5'h00);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
